taxi_fare_scheduler: RTL and testbench

Charge scheduler for the taxi meter. It turns seat occupancy, VIP mode and the metering tick into individual fare charges, then feeds them one at a time over a valid/ready port to the single shared fare adder. It keeps the running income tally and enforces the income cap. It sits between the cabin sensors and the fare accumulator datapath.

---
 rtl/taxi_fare_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_taxi_fare_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_fare_scheduler.sv
// taxi_fare_scheduler
// Turns seat occupancy, VIP mode and the metering tick into individual fare
// charges. Charges go one at a time over a valid/ready port to the shared fare
// adder. The block also keeps the running income tally and enforces the income cap.
//
// Ports
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   tick, mode            : metering pulse; mode 1 = motion, 0 = stopped
//   vip_enable, seat_occ  : VIP hire active; per-seat occupancy
//   clear_income          : synchronous clear of income and all charges
//   add_valid/dest/amount : registered charge offer (dest 0-3 seat, 4 VIP)
//   add_ready             : adder accepts the offered charge
//   clear_dest            : one-cycle pulse per destination fare register
//   total_income          : sum of accepted charges
//   overrun               : sticky, a tick hit a slot whose rate charge was pending
//
// Build option: define TAXI_SCHED_FIXED_PRIORITY_EN for fixed priority
// VIP > seat0 > seat1 > seat2 > seat3. Without it, arbitration is round-robin.
//
// Slot states
//   state | meaning
//   IDLE  | slot unoccupied, no charges generated
//   RIDE  | slot hired: flag charge on entry, one rate charge per tick
module taxi_fare_scheduler #(
   parameter logic [7:0]  FLAG_FARE     = 8'd10,
   parameter logic [7:0]  MOVE_RATE     = 8'd8,
   parameter logic [7:0]  WAIT_RATE     = 8'd5,
   parameter logic [7:0]  VIP_MOVE_RATE = 8'd16,
   parameter logic [31:0] INCOME_LIMIT  = 32'd10000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        mode,
   input  logic        vip_enable,
   input  logic [3:0]  seat_occ,
   input  logic        clear_income,
   output logic        add_valid,
   output logic [2:0]  add_dest,
   output logic [7:0]  add_amount,
   input  logic        add_ready,
   output logic [4:0]  clear_dest,
   output logic [31:0] total_income,
   output logic        overrun
);
   typedef enum logic {IDLE = 1'b0, RIDE = 1'b1} slot_state_t;

   localparam int NSLOT = 5;
   localparam int VIP   = 4;

   slot_state_t      st_q [NSLOT];
   slot_state_t      st_d [NSLOT];
   logic [7:0]       rval_q [NSLOT];
   logic [7:0]       rval_d [NSLOT];
   logic [NSLOT-1:0] flag_q, flag_d, rate_q, rate_d;
   logic [3:0]       occ_q, occ_qq, seat_rise, seat_fall;
   logic             vip_q, vip_qq, vip_rise, vip_fall;
   logic             offer_flag_q;
`ifndef TAXI_SCHED_FIXED_PRIORITY_EN
   logic [2:0]       ptr_q;
   logic [3:0]       rr_sum;
`endif
   logic [4:0]       clr_d;
   logic             ovr_d, accept, cap_hit, offer_live, win_found, win_flag;
   logic [2:0]       win_idx, arb_idx;
   logic [7:0]       win_amount;
   logic [32:0]      income_sum;

   assign accept     = add_valid & add_ready;
   assign income_sum = {1'b0, total_income} + {25'd0, add_amount};
   assign cap_hit    = accept && (income_sum > {1'b0, INCOME_LIMIT});
   assign seat_rise  = occ_q & ~occ_qq;
   assign seat_fall  = ~occ_q & occ_qq;
   assign vip_rise   = vip_q & ~vip_qq;
   assign vip_fall   = ~vip_q & vip_qq;

   // Next slot state: ticks first, then acceptance, then occupancy events,
   // so an alighting slot loses whatever the same-cycle tick would have added.
   always_comb begin
      st_d   = st_q;
      rval_d = rval_q;
      flag_d = flag_q;
      rate_d = rate_q;
      clr_d  = '0;
      ovr_d  = overrun;
      if (tick) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (st_q[i] == RIDE) begin
               if (rate_q[i]) begin
                  ovr_d = 1'b1;
               end else begin
                  rate_d[i] = 1'b1;
                  if (!mode)         rval_d[i] = WAIT_RATE;
                  else if (i == VIP) rval_d[i] = VIP_MOVE_RATE;
                  else               rval_d[i] = MOVE_RATE;
               end
            end
         end
      end
      if (accept) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (add_dest == 3'(i)) begin
               if (offer_flag_q) flag_d[i] = 1'b0;
               else              rate_d[i] = 1'b0;
            end
         end
      end
      if (vip_rise) begin
         st_d[VIP]   = RIDE;
         flag_d[VIP] = 1'b1;
         clr_d[3:0]  = 4'hF;
         for (int i = 0; i < 4; i++) begin
            st_d[i]   = IDLE;
            flag_d[i] = 1'b0;
            rate_d[i] = 1'b0;
         end
      end else if (vip_fall) begin
         st_d[VIP]   = IDLE;
         flag_d[VIP] = 1'b0;
         rate_d[VIP] = 1'b0;
         clr_d[VIP]  = 1'b1;
         // Seats occupied during the VIP hire board now.
         for (int i = 0; i < 4; i++) begin
            if (occ_q[i] && st_q[i] == IDLE) begin
               st_d[i]   = RIDE;
               flag_d[i] = 1'b1;
            end
         end
      end else if (!vip_q) begin
         for (int i = 0; i < 4; i++) begin
            if (seat_rise[i] && st_q[i] == IDLE) begin
               st_d[i]   = RIDE;
               flag_d[i] = 1'b1;
            end else if (seat_fall[i] && st_q[i] == RIDE) begin
               st_d[i]   = IDLE;
               flag_d[i] = 1'b0;
               rate_d[i] = 1'b0;
               clr_d[i]  = 1'b1;
            end
         end
      end
      if (cap_hit) begin
         flag_d = '0;
         rate_d = '0;
         clr_d  = '1;
      end
   end

   // Arbitrate over next-cycle pending bits so a tick is offered on the very next edge.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      win_flag   = 1'b0;
      win_amount = '0;
      offer_live = 1'b0;
      arb_idx    = '0;
`ifndef TAXI_SCHED_FIXED_PRIORITY_EN
      rr_sum     = '0;
`endif
      for (int k = 0; k < NSLOT; k++) begin
`ifdef TAXI_SCHED_FIXED_PRIORITY_EN
         arb_idx = (k == 0) ? 3'd4 : 3'(k - 1);
`else
         rr_sum = {1'b0, ptr_q} + 4'(k + 1);
         if (rr_sum >= 4'd5) rr_sum = rr_sum - 4'd5;
         arb_idx = rr_sum[2:0];
`endif
         if (!win_found && (flag_d[arb_idx] || rate_d[arb_idx])) begin
            win_found  = 1'b1;
            win_idx    = arb_idx;
            win_flag   = flag_d[arb_idx];
            win_amount = flag_d[arb_idx] ? FLAG_FARE : rval_d[arb_idx];
         end
      end
      for (int i = 0; i < NSLOT; i++) begin
         if (add_dest == 3'(i)) offer_live = offer_flag_q ? flag_d[i] : rate_d[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSLOT; i++) begin
            st_q[i]   <= IDLE;
            rval_q[i] <= '0;
         end
         flag_q       <= '0;
         rate_q       <= '0;
         occ_q        <= '0;
         occ_qq       <= '0;
         vip_q        <= 1'b0;
         vip_qq       <= 1'b0;
         offer_flag_q <= 1'b0;
`ifndef TAXI_SCHED_FIXED_PRIORITY_EN
         ptr_q        <= '0;
`endif
         add_valid    <= 1'b0;
         add_dest     <= '0;
         add_amount   <= '0;
         clear_dest   <= '0;
         total_income <= '0;
         overrun      <= 1'b0;
      end else if (clear_income) begin
         for (int i = 0; i < NSLOT; i++) st_q[i] <= IDLE;
         flag_q       <= '0;
         rate_q       <= '0;
         // Forgetting the sampled inputs makes occupied seats re-board afterwards.
         occ_q        <= '0;
         occ_qq       <= '0;
         vip_q        <= 1'b0;
         vip_qq       <= 1'b0;
         add_valid    <= 1'b0;
         clear_dest   <= '1;
         total_income <= '0;
         overrun      <= 1'b0;
      end else begin
         st_q       <= st_d;
         rval_q     <= rval_d;
         flag_q     <= flag_d;
         rate_q     <= rate_d;
         occ_q      <= seat_occ;
         occ_qq     <= occ_q;
         vip_q      <= vip_enable;
         vip_qq     <= vip_q;
         clear_dest <= clr_d;
         overrun    <= ovr_d;
         if (cap_hit)     total_income <= '0;
         else if (accept) total_income <= income_sum[31:0];
         if (cap_hit) begin
            add_valid <= 1'b0;
         end else if (add_valid && !add_ready) begin
            // Hold the offer; withdraw only if its slot dropped the charge.
            if (!offer_live) add_valid <= 1'b0;
         end else if (win_found) begin
            add_valid    <= 1'b1;
            add_dest     <= win_idx;
            add_amount   <= win_amount;
            offer_flag_q <= win_flag;
`ifndef TAXI_SCHED_FIXED_PRIORITY_EN
            ptr_q        <= win_idx;
`endif
         end else begin
            add_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_taxi_fare_scheduler.sv
module tb_taxi_fare_scheduler;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick = 1'b0;
   logic        mode = 1'b0;
   logic        vip_enable = 1'b0;
   logic [3:0]  seat_occ = 4'd0;
   logic        clear_income = 1'b0;
   logic        add_ready = 1'b0;
   logic        add_valid;
   logic [2:0]  add_dest;
   logic [7:0]  add_amount;
   logic [4:0]  clear_dest;
   logic [31:0] total_income;
   logic        overrun;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;

   taxi_fare_scheduler dut (
      .clock(clock), .reset_n(reset_n), .tick(tick), .mode(mode),
      .vip_enable(vip_enable), .seat_occ(seat_occ), .clear_income(clear_income),
      .add_valid(add_valid), .add_dest(add_dest), .add_amount(add_amount),
      .add_ready(add_ready), .clear_dest(clear_dest),
      .total_income(total_income), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // Scoreboard: every accepted charge must match the oldest expected one.
   always @(negedge clock) begin
      if (reset_n && add_valid && add_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_charge: got dest %0d amount %0d, required none", add_dest, add_amount);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({add_dest, add_amount} !== mon_exp)
               $display("FAIL charge: got dest %0d amount %0d, required dest %0d amount %0d",
                        add_dest, add_amount, mon_exp[10:8], mon_exp[7:0]);
            else n_pass++;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_tick(input logic m);
      mode = m;
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      step(2);
      ok = (exp_q.size() == 0);
   endtask

   task automatic do_clear();
      seat_occ = 4'd0;
      vip_enable = 1'b0;
      tick = 1'b0;
      step(4);
      clear_income = 1'b1;
      step();
      clear_income = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(2);
      n_checks++; if (add_valid !== 1'b0) $display("FAIL reset_valid: got %0b required 0", add_valid); else n_pass++;
      n_checks++; if (add_dest !== 3'd0) $display("FAIL reset_dest: got %0d required 0", add_dest); else n_pass++;
      n_checks++; if (add_amount !== 8'd0) $display("FAIL reset_amount: got %0d required 0", add_amount); else n_pass++;
      n_checks++; if (clear_dest !== 5'd0) $display("FAIL reset_clear_dest: got %b required 00000", clear_dest); else n_pass++;
      n_checks++; if (total_income !== 32'd0) $display("FAIL reset_income: got %0d required 0", total_income); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b required 0", overrun); else n_pass++;
      reset_n = 1'b1;
      step(3);
   endtask

   task automatic test_basic_ride();
      bit ok;
      add_ready = 1'b1;
      mode = 1'b1;
      seat_occ = 4'b0001;
      exp_q.push_back({3'd0, 8'd10});
      step();
      @(negedge clock);
      n_checks++; if (add_valid !== 1'b0) $display("FAIL board_early: got valid %0b required 0", add_valid); else n_pass++;
      step();
      @(negedge clock);
      n_checks++; if (add_valid !== 1'b1) $display("FAIL board_latency: got valid %0b required 1", add_valid); else n_pass++;
      wait_drain(20, ok);
      exp_q.push_back({3'd0, 8'd8});
      pulse_tick(1'b1);
      @(negedge clock);
      n_checks++; if (add_valid !== 1'b1) $display("FAIL tick_latency: got valid %0b required 1", add_valid); else n_pass++;
      step(2);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({3'd0, 8'd8});
         pulse_tick(1'b1);
         step(3);
      end
      wait_drain(20, ok);
      n_checks++; if (!ok) begin $display("FAIL basic_drain: %0d charges outstanding, required 0", exp_q.size()); exp_q.delete(); end else n_pass++;
      n_checks++; if (total_income !== 32'd34) $display("FAIL basic_income: got %0d required 34", total_income); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok;
      int first = -1, last = -1, cnt = 0;
      seat_occ = 4'd0;
      tick = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step(3);
      add_ready = 1'b1;
      seat_occ = 4'hF;
`ifdef TAXI_SCHED_FIXED_PRIORITY_EN
      for (int d = 0; d < 4; d++) exp_q.push_back({3'(d), 8'd10});
`else
      exp_q.push_back({3'd1, 8'd10});
      exp_q.push_back({3'd2, 8'd10});
      exp_q.push_back({3'd3, 8'd10});
      exp_q.push_back({3'd0, 8'd10});
`endif
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (add_valid) begin
            if (first < 0) first = i;
            last = i;
            cnt++;
         end
      end
      n_checks++;
      if (cnt != 4 || last - first != 3) $display("FAIL rr_back_to_back: got %0d valid cycles over span %0d, required 4 over 4", cnt, last - first + 1);
      else n_pass++;
      wait_drain(20, ok);
      n_checks++; if (!ok) begin $display("FAIL rr_drain: %0d charges outstanding, required 0", exp_q.size()); exp_q.delete(); end else n_pass++;
      n_checks++; if (total_income !== 32'd40) $display("FAIL rr_income: got %0d required 40", total_income); else n_pass++;
   endtask

   task automatic test_overrun();
      bit ok;
      do_clear();
      add_ready = 1'b1;
      seat_occ = 4'b0001;
      exp_q.push_back({3'd0, 8'd10});
      wait_drain(20, ok);
      add_ready = 1'b0;
      exp_q.push_back({3'd0, 8'd5});
      pulse_tick(1'b0);
      step(2);
      pulse_tick(1'b0);
      @(negedge clock);
      n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %0b required 1", overrun); else n_pass++;
      n_checks++; if (add_valid !== 1'b1 || add_amount !== 8'd5) $display("FAIL overrun_hold: got valid %0b amount %0d, required 1 and 5", add_valid, add_amount); else n_pass++;
      step(2);
      add_ready = 1'b1;
      wait_drain(20, ok);
      step(4);
      n_checks++; if (!ok) begin $display("FAIL overrun_drain: %0d charges outstanding, required 0", exp_q.size()); exp_q.delete(); end else n_pass++;
      n_checks++; if (total_income !== 32'd15) $display("FAIL overrun_income: got %0d required 15", total_income); else n_pass++;
      n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0b required 1", overrun); else n_pass++;
   endtask

   task automatic test_vip();
      bit ok, got;
      logic [4:0] cd;
      do_clear();
      n_checks++; if (overrun !== 1'b0 || total_income !== 32'd0) $display("FAIL clear_income: got overrun %0b income %0d, required 0 and 0", overrun, total_income); else n_pass++;
      add_ready = 1'b1;
      seat_occ = 4'b0110;
      exp_q.push_back({3'd1, 8'd10});
      exp_q.push_back({3'd2, 8'd10});
      wait_drain(20, ok);
      vip_enable = 1'b1;
      exp_q.push_back({3'd4, 8'd10});
      got = 1'b0;
      cd = '0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clock);
         if (clear_dest != 5'd0) begin got = 1'b1; cd = clear_dest; end
      end
      n_checks++; if (cd !== 5'b01111) $display("FAIL vip_clear_dest: got %b required 01111", cd); else n_pass++;
      @(negedge clock);
      n_checks++; if (clear_dest !== 5'd0) $display("FAIL vip_clear_width: got %b required 00000", clear_dest); else n_pass++;
      wait_drain(20, ok);
      exp_q.push_back({3'd4, 8'd16});
      pulse_tick(1'b1);
      step(2);
      exp_q.push_back({3'd4, 8'd16});
      pulse_tick(1'b1);
      step(2);
      exp_q.push_back({3'd4, 8'd5});
      pulse_tick(1'b0);
      wait_drain(20, ok);
      n_checks++; if (total_income !== 32'd67) $display("FAIL vip_income: got %0d required 67", total_income); else n_pass++;
      vip_enable = 1'b0;
      exp_q.push_back({3'd1, 8'd10});
      exp_q.push_back({3'd2, 8'd10});
      got = 1'b0;
      cd = '0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clock);
         if (clear_dest != 5'd0) begin got = 1'b1; cd = clear_dest; end
      end
      n_checks++; if (cd !== 5'b10000) $display("FAIL vip_exit_clear: got %b required 10000", cd); else n_pass++;
      wait_drain(20, ok);
      n_checks++; if (!ok) begin $display("FAIL vip_drain: %0d charges outstanding, required 0", exp_q.size()); exp_q.delete(); end else n_pass++;
      n_checks++; if (total_income !== 32'd87) $display("FAIL vip_reboard_income: got %0d required 87", total_income); else n_pass++;
   endtask

   task automatic test_income_cap();
      bit ok;
      do_clear();
      add_ready = 1'b1;
      mode = 1'b1;
      seat_occ = 4'b0001;
      exp_q.push_back({3'd0, 8'd10});
      wait_drain(20, ok);
      for (int i = 0; i < 1248; i++) begin
         exp_q.push_back({3'd0, 8'd8});
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
      wait_drain(20, ok);
      n_checks++; if (total_income !== 32'd9994) $display("FAIL cap_preload: got %0d required 9994", total_income); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL cap_no_overrun: got %0b required 0", overrun); else n_pass++;
      exp_q.push_back({3'd0, 8'd8});
      pulse_tick(1'b1);
      @(negedge clock);
      step();
      @(negedge clock);
      n_checks++; if (total_income !== 32'd0) $display("FAIL cap_income: got %0d required 0", total_income); else n_pass++;
      n_checks++; if (clear_dest !== 5'b11111) $display("FAIL cap_clear_dest: got %b required 11111", clear_dest); else n_pass++;
      step(2);
      exp_q.push_back({3'd0, 8'd8});
      pulse_tick(1'b1);
      wait_drain(20, ok);
      n_checks++; if (!ok) begin $display("FAIL cap_drain: %0d charges outstanding, required 0", exp_q.size()); exp_q.delete(); end else n_pass++;
      n_checks++; if (total_income !== 32'd8) $display("FAIL cap_state_kept: got %0d required 8", total_income); else n_pass++;
   endtask

   task automatic test_reset_mid_offer();
      add_ready = 1'b0;
      pulse_tick(1'b1);
      @(negedge clock);
      n_checks++; if (add_valid !== 1'b1) $display("FAIL mid_offer_setup: got valid %0b required 1", add_valid); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (add_valid !== 1'b0 || add_dest !== 3'd0 || add_amount !== 8'd0 ||
          clear_dest !== 5'd0 || total_income !== 32'd0 || overrun !== 1'b0)
         $display("FAIL async_reset: got valid %0b dest %0d amount %0d clear %b income %0d overrun %0b, required all 0",
                  add_valid, add_dest, add_amount, clear_dest, total_income, overrun);
      else n_pass++;
      exp_q.delete();
      step(2);
      reset_n = 1'b1;
      step(3);
   endtask

   initial begin
      test_reset();
      test_basic_ride();
      test_round_robin();
      test_overrun();
      test_vip();
      test_income_cap();
      test_reset_mid_offer();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
